keypad_cmd: RTL

KEYPAD_CMD -- requirements
Module: keypad_cmd

---
 rtl/connect4_pkg.sv | 35 +++
 rtl/key_debounce.sv | 33 +++
 rtl/keypad_cmd.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, keypad codes, keypad FSM states, command type.
package connect4_pkg;

    localparam int unsigned NUM_COLS = 7;
    localparam int unsigned COL_W    = $clog2(NUM_COLS);

    localparam logic [3:0] KEY_COL_FIRST = 4'h1;
    localparam logic [3:0] KEY_COL_LAST  = 4'h7;
    localparam logic [3:0] KEY_MODE      = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StReleaseDb
    } kp_state_e;

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic             pop;
    } cmd_t;

    // True for keys that select a column.
    function automatic logic is_col_key(input logic [3:0] code);
        return (code >= KEY_COL_FIRST) && (code <= KEY_COL_LAST);
    endfunction

    // Column index for a column key (key 1 is column 0).
    function automatic logic [COL_W-1:0] key_to_col(input logic [3:0] code);
        logic [3:0] w_diff;
        w_diff = code - KEY_COL_FIRST;
        return w_diff[COL_W-1:0];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Saturating debounce counter: cleared on request, counts while enabled, flags the last count.
// Shared by the keypad path and the board buttons.
module key_debounce
    import connect4_pkg::*;
#(
    parameter int unsigned CYCLES = 1000000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int unsigned     CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_done = (r_count == CNT_LAST);

    // Count up while enabled; holds at CNT_LAST so it never wraps.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_cmd.sv
// Keypad to game-command front end: synchronizes and debounces the "key held" level, decodes one
// key per physical press into a column command held in a one-entry valid/ready register.
// Optional feature macro: KEYPAD_CMD_POP_EN (pop mode toggled by key 0xF).
module keypad_cmd
    import connect4_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_press,
    input  logic [3:0] key_code,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_col,
    output logic       cmd_pop,
    output logic       pop_mode,
    output logic       cmd_drop_err
);

    logic      r_sync1;
    logic      r_sync2;
    logic      w_press;
    kp_state_e r_state;
    kp_state_e w_state_next;
    logic      w_cnt_clear;
    logic      w_cnt_en;
    logic      w_cnt_done;
    logic      w_decode;
    logic      w_cmd_new;
    logic      w_pop_mode;
    cmd_t      r_cmd;
    logic      r_valid;
    logic      r_drop_err;

    // Two-flop synchronizer for the asynchronous key level.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_press;
            r_sync2 <= r_sync1;
        end
    end

    assign w_press = r_sync2;

    key_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .clr_n    (clr_n),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_done   (w_cnt_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; w_decode fires once per accepted press.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_decode     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_clear = 1'b1;
                if (w_press) begin
                    w_state_next = StPressDb;
                end
            end
            StPressDb: begin
                if (!w_press) begin
                    w_state_next = StIdle;
                end else if (w_cnt_done) begin
                    w_state_next = StHeld;
                    w_decode     = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StHeld: begin
                w_cnt_clear = 1'b1;
                if (!w_press) begin
                    w_state_next = StReleaseDb;
                end
            end
            StReleaseDb: begin
                if (w_press) begin
                    w_state_next = StHeld;
                end else if (w_cnt_done) begin
                    w_state_next = StIdle;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_cmd_new = w_decode && is_col_key(key_code);

`ifdef KEYPAD_CMD_POP_EN
    logic r_pop_mode;

    // Mode key flips pop/drop mode; a pending command keeps the mode it was captured with.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pop_mode <= 1'b0;
        end else if (w_decode && (key_code == KEY_MODE)) begin
            r_pop_mode <= ~r_pop_mode;
        end
    end

    assign w_pop_mode = r_pop_mode;
`else
    assign w_pop_mode = 1'b0;
`endif

    // One-entry command register: load when empty or draining this cycle, otherwise drop and flag.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_drop_err <= 1'b0;
            if (w_cmd_new) begin
                if (!r_valid || cmd_ready) begin
                    r_valid   <= 1'b1;
                    r_cmd.col <= key_to_col(key_code);
                    r_cmd.pop <= w_pop_mode;
                end else begin
                    r_drop_err <= 1'b1;
                end
            end else if (r_valid && cmd_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cmd_valid    = r_valid;
    assign cmd_col      = r_cmd.col;
    assign cmd_pop      = r_cmd.pop;
    assign pop_mode     = w_pop_mode;
    assign cmd_drop_err = r_drop_err;

endmodule
